decode_cycle: RTL and testbench
===============================

DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port InstrD, input, 32 bits: instruction from the fetch stage.
REQ-004 SHALL have ports PCD and PCPlus4D, input, 32 bits each: PC and PC+4 from the fetch stage.
REQ-005 SHALL have ports RegWriteW (input, 1 bit), RDW (input, 5 bits) and ResultW (input, 32 bits): writeback write-enable, destination register and data.
REQ-006 SHALL have port FlushE, input, 1 bit: converts the next ID/EX contents into a bubble.
REQ-007 SHALL have outputs RegWriteE, MemWriteE, JumpE, BranchE and ALUSrcE, 1 bit each: registered control signals.
REQ-008 SHALL have output ResultSrcE, 2 bits: 00 ALU, 01 memory, 10 PC+4.
REQ-009 SHALL have output ALUControlE, 3 bits: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 SHALL have outputs RD1E, RD2E, ImmExtE, PCE and PCPlus4E, 32 bits each: registered operands, immediate and PCs.
REQ-011 SHALL have outputs RdE, Rs1E and Rs2E, 5 bits each: registered register indices.
REQ-012 SHALL have outputs Rs1D and Rs2D, 5 bits each: combinational InstrD[19:15] and InstrD[24:20], for the hazard unit.

Function
REQ-013 SHALL contain a 32x32 register file with 2 combinational read ports and 1 write port; writes occur on the clock edge when RegWriteW=1 and RDW!=0.
REQ-014 SHALL read x0 as 0 at all times; a write to x0 SHALL have no effect.
REQ-015 SHALL bypass a same-cycle write: when RegWriteW=1, RDW!=0 and RDW equals a source index, that read port SHALL return ResultW.
REQ-016 SHALL decode opcodes as follows (RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump, ImmSrc):
- 0000011 lw: 1, 1, 0, 01, 0, 0, I
- 0100011 sw: 0, 1, 1, 00, 0, 0, S
- 0110011 R-type: 1, 0, 0, 00, 0, 0, none
- 0010011 I-ALU: 1, 1, 0, 00, 0, 0, I
- 1100011 beq: 0, 0, 0, 00, 1, 0, B
- 1101111 jal: 1, 0, 0, 10, 0, 1, J
REQ-017 SHALL drive all control outputs to 0 for any other opcode (illegal-instruction bubble).
REQ-018 SHALL select ALUControl as follows:
- lw/sw: add.
- beq: sub.
- R-type and I-ALU by funct3: 000 gives add, except R-type with funct7[5]=1 gives sub; 010 gives slt; 110 gives or; 111 gives and.
- Any other funct3: add.
REQ-019 SHALL sign-extend immediates from InstrD[31] as follows:
- I: [31:20].
- S: {[31:25],[11:7]}.
- B: {[31],[7],[30:25],[11:8],0}.
- J: {[31],[19:12],[20],[30:21],0}.
- None: 0.
REQ-020 SHALL register all E-side outputs in the ID/EX register on every rising edge, giving 1-cycle latency from InstrD to the E outputs.
REQ-021 SHALL load all ID/EX fields with 0 on the next edge when FlushE=1.
REQ-022 SHALL let a register-file write and a flush in the same cycle both take effect.

Reset
REQ-023 SHALL clear all 32 registers and every ID/EX field to 0 on a rising edge with rst=1.
REQ-024 SHALL give rst priority over FlushE and over the register-file write.
REQ-025 SHALL, after reset is asserted mid-operation, take effect on the next edge, with all E outputs 0 one edge after rst rises.

Verification
REQ-026 SHALL be verified by the following bench scenarios:
- Reset: rst=1 for 2 cycles with InstrD=0x00500093 -> all E outputs 0 and RD1E=0 throughout.
- I-ALU: InstrD=0x00500093 (addi x1,x0,5) -> next edge RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000, ResultSrcE=00.
- Branch: InstrD=0xFE208EE3 (beq x1,x2,-4) -> BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC, RegWriteE=0, Rs1E=1, Rs2E=2.
- Bypass: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF with InstrD=0x00018233 (add x4,x3,x0) -> RD1E=0xDEADBEEF, RD2E=0; a later read of x3 returns 0xDEADBEEF.
- x0 write: RegWriteW=1, RDW=0, ResultW=0x12345678, then read x0 -> RD1E=0.
- Flush: FlushE=1 with InstrD=0x0020A423 (sw x2,8(x1)) -> next edge MemWriteE=0 and all E outputs 0; with FlushE=0 -> MemWriteE=1, ImmExtE=8.

Source files
------------

// File: rtl/decode_cycle.sv
// Decode stage of a 5-stage RV32I pipeline: register file, main/ALU decoders,
// immediate extension and the ID/EX pipeline register.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RdE,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_J    = 3'd4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic        aluSrc;
        logic [1:0]  resultSrc;
        logic [2:0]  aluControl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] immExt;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } idEx_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rdD;
    logic [31:0] regs [32];
    logic [31:0] rd1D, rd2D, immExtD;
    logic [2:0]  immSrc;
    idEx_t       idExD, idExQ;

    assign opcode   = InstrD[6:0];
    assign funct3   = InstrD[14:12];
    assign funct7b5 = InstrD[30];
    assign rdD      = InstrD[11:7];
    assign Rs1D     = InstrD[19:15];
    assign Rs2D     = InstrD[24:20];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (RegWriteW && RDW != 5'd0) begin
            regs[RDW] <= ResultW;
        end
    end

    // x0 is hardwired; a write landing this cycle is forwarded to the reader.
    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (Rs1D != 5'd0) rd1D = (RegWriteW && RDW == Rs1D) ? ResultW : regs[Rs1D];
        if (Rs2D != 5'd0) rd2D = (RegWriteW && RDW == Rs2D) ? ResultW : regs[Rs2D];
    end

    always_comb begin
        idExD  = '0;
        immSrc = IMM_NONE;
        unique case (opcode)
            OP_LW: begin
                idExD.regWrite = 1'b1; idExD.aluSrc = 1'b1;
                idExD.resultSrc = 2'b01; immSrc = IMM_I;
            end
            OP_SW: begin
                idExD.aluSrc = 1'b1; idExD.memWrite = 1'b1; immSrc = IMM_S;
            end
            OP_R: idExD.regWrite = 1'b1;
            OP_I: begin
                idExD.regWrite = 1'b1; idExD.aluSrc = 1'b1; immSrc = IMM_I;
            end
            OP_BEQ: begin
                idExD.branch = 1'b1; immSrc = IMM_B;
            end
            OP_JAL: begin
                idExD.regWrite = 1'b1; idExD.resultSrc = 2'b10;
                idExD.jump = 1'b1; immSrc = IMM_J;
            end
            default: ;
        endcase

        idExD.aluControl = ALU_ADD;
        if (opcode == OP_BEQ) begin
            idExD.aluControl = ALU_SUB;
        end else if (opcode == OP_R || opcode == OP_I) begin
            unique case (funct3)
                3'b000:  idExD.aluControl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  idExD.aluControl = ALU_SLT;
                3'b110:  idExD.aluControl = ALU_OR;
                3'b111:  idExD.aluControl = ALU_AND;
                default: idExD.aluControl = ALU_ADD;
            endcase
        end

        idExD.rd1     = rd1D;
        idExD.rd2     = rd2D;
        idExD.immExt  = immExtD;
        idExD.pc      = PCD;
        idExD.pcPlus4 = PCPlus4D;
        idExD.rd      = rdD;
        idExD.rs1     = Rs1D;
        idExD.rs2     = Rs2D;
    end

    always_comb begin
        unique case (immSrc)
            IMM_I:   immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   immExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   immExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: immExtD = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || FlushE) idExQ <= '0;
        else               idExQ <= idExD;
    end

    assign RegWriteE   = idExQ.regWrite;
    assign MemWriteE   = idExQ.memWrite;
    assign JumpE       = idExQ.jump;
    assign BranchE     = idExQ.branch;
    assign ALUSrcE     = idExQ.aluSrc;
    assign ResultSrcE  = idExQ.resultSrc;
    assign ALUControlE = idExQ.aluControl;
    assign RD1E        = idExQ.rd1;
    assign RD2E        = idExQ.rd2;
    assign ImmExtE     = idExQ.immExt;
    assign PCE         = idExQ.pc;
    assign PCPlus4E    = idExQ.pcPlus4;
    assign RdE         = idExQ.rd;
    assign Rs1E        = idExQ.rs1;
    assign Rs2E        = idExQ.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed-vector bench for decode_cycle with hand-computed expectations.
module tb_decode_cycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
    logic        RegWriteW, FlushE;
    logic [4:0]  RDW;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  RdE, Rs1E, Rs2E, Rs1D, Rs2D;

    int nChecks = 0;
    int nPass   = 0;

    decode_cycle dut (
        .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .Rs1D(Rs1D), .Rs2D(Rs2D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Control bits packed as {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc, ALUControl}
    function automatic logic [31:0] ctrlE();
        return {22'd0, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};
    endfunction

    task automatic chkAllZero(input string tag);
        chk({tag, ".ctrl"}, ctrlE(), 32'd0);
        chk({tag, ".rd1"}, RD1E, 32'd0);
        chk({tag, ".rd2"}, RD2E, 32'd0);
        chk({tag, ".imm"}, ImmExtE, 32'd0);
        chk({tag, ".pc"}, PCE, 32'd0);
        chk({tag, ".pc4"}, PCPlus4E, 32'd0);
        chk({tag, ".regs"}, {17'd0, RdE, Rs1E, Rs2E}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
        RegWriteW = 1'b0; RDW = 5'd0; ResultW = '0; FlushE = 1'b0;

        tick(); chkAllZero("rst1");
        tick(); chkAllZero("rst2");
        chk("rs1D", {27'd0, Rs1D}, 32'd0);
        chk("rs2D", {27'd0, Rs2D}, 32'd5);

        // addi x1,x0,5
        rst = 1'b0;
        tick();
        chk("addi.ctrl", ctrlE(), 32'b1_0_0_0_1_00_000);
        chk("addi.imm", ImmExtE, 32'd5);
        chk("addi.rd", {27'd0, RdE}, 32'd1);
        chk("addi.pc", PCE, 32'h100);
        chk("addi.pc4", PCPlus4E, 32'h104);

        // beq x1,x2,-4
        InstrD = 32'hFE208EE3;
        tick();
        chk("beq.ctrl", ctrlE(), 32'b0_0_0_1_0_00_001);
        chk("beq.imm", ImmExtE, 32'hFFFFFFFC);
        chk("beq.rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd1, 5'd2});

        // add x4,x3,x0 while x3 is being written back
        InstrD = 32'h00018233; RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hDEADBEEF;
        tick();
        chk("byp.rd1", RD1E, 32'hDEADBEEF);
        chk("byp.rd2", RD2E, 32'd0);
        chk("byp.ctrl", ctrlE(), 32'b1_0_0_0_0_00_000);
        chk("byp.rd", {27'd0, RdE}, 32'd4);

        // sub x4,x3,x0 reads x3 from the array
        RegWriteW = 1'b0; InstrD = 32'h40018233;
        tick();
        chk("x3.rd1", RD1E, 32'hDEADBEEF);
        chk("sub.alu", {29'd0, ALUControlE}, 32'b001);

        // write to x0 must be ignored, also on the bypass path
        InstrD = 32'h00000033; RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h12345678;
        tick();
        chk("x0byp.rd1", RD1E, 32'd0);
        RegWriteW = 1'b0;
        tick();
        chk("x0.rd1", RD1E, 32'd0);

        // flushed sw, with a concurrent write of x5
        InstrD = 32'h0020A423; FlushE = 1'b1; RegWriteW = 1'b1; RDW = 5'd5; ResultW = 32'hCAFEF00D;
        tick();
        chkAllZero("flush");
        FlushE = 1'b0; RegWriteW = 1'b0;
        tick();
        chk("sw.ctrl", ctrlE(), 32'b0_1_0_0_1_00_000);
        chk("sw.imm", ImmExtE, 32'd8);
        chk("sw.rs", {22'd0, Rs1E, Rs2E}, {22'd0, 5'd1, 5'd2});

        // addi x6,x5,0: the write made during the flush landed
        InstrD = 32'h00028313;
        tick();
        chk("x5.rd1", RD1E, 32'hCAFEF00D);

        // jal x1,8
        InstrD = 32'h008000EF;
        tick();
        chk("jal.ctrl", ctrlE(), 32'b1_0_1_0_0_10_000);
        chk("jal.imm", ImmExtE, 32'd8);

        // slt x3,x1,x2 and ori x1,x0,-1
        InstrD = 32'h0020A1B3;
        tick();
        chk("slt.alu", {29'd0, ALUControlE}, 32'b101);
        InstrD = 32'hFFF06093;
        tick();
        chk("ori.alu", {29'd0, ALUControlE}, 32'b011);
        chk("ori.imm", ImmExtE, 32'hFFFFFFFF);

        // illegal opcode gives a control bubble
        InstrD = 32'hFFFFFFFF;
        tick();
        chk("ill.ctrl", ctrlE(), 32'd0);
        chk("ill.imm", ImmExtE, 32'd0);

        // mid-run reset beats a write and a valid instruction
        rst = 1'b1; InstrD = 32'h00718233; RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'h55AA55AA;
        tick();
        chkAllZero("rstmid");
        rst = 1'b0; RegWriteW = 1'b0;
        tick();
        chk("rstx3.rd1", RD1E, 32'd0);
        chk("rstx7.rd2", RD2E, 32'd0);
        chk("rst.ctrl", ctrlE(), 32'b1_0_0_0_0_00_000);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
